// File: rtl/div_seq_pkg.sv
// Shared encodings for the iterative divider: FSM states, handshake levels
// and the ALU op codes that route DIV/DIVU to this unit.
package div_seq_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_CNT_W  = 6;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [DIV_CNT_W-1:0] DIV_CNT_MAX = DIV_CNT_W'(DIV_DATA_W - 1);

  // Appended to the 8-bit ALU op space so decode can select the divider.
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_seq.sv
// Radix-2 restoring divider sequencer for DIV/DIVU in EX. One quotient bit
// per cycle; returns {remainder, quotient} with a registered ready flag.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DATA_W - 1);

  div_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   rem_q;
  logic [DATA_W-1:0]   quo_q;
  logic [DATA_W-1:0]   divisor_q;
  logic [2*DATA_W-1:0] res_q;
  logic                signed_q;
  logic                a_neg_q;
  logic                b_neg_q;

  logic [DATA_W:0]     trial;
  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   rem_d;
  logic [DATA_W-1:0]   quo_d;
  logic [DATA_W-1:0]   fix_rem;
  logic [DATA_W-1:0]   fix_quo;
  logic [DATA_W-1:0]   a_abs;
  logic [DATA_W-1:0]   b_abs;
  logic                a_neg;
  logic                b_neg;

  // Operand conditioning at start: magnitudes only enter the datapath.
  always_comb begin
    a_neg = signed_div_i & opdata1_i[DATA_W-1];
    b_neg = signed_div_i & opdata2_i[DATA_W-1];
    a_abs = a_neg ? -opdata1_i : opdata1_i;
    b_abs = b_neg ? -opdata2_i : opdata2_i;
  end

  // The trial is DATA_W+1 bits: with a divisor above 2^(DATA_W-1) the shifted
  // remainder can exceed DATA_W bits before the subtract brings it back.
  always_comb begin
    trial = {rem_q, quo_q[DATA_W-1]};
    diff  = trial - {1'b0, divisor_q};
    if (!diff[DATA_W]) begin
      rem_d = diff[DATA_W-1:0];
      quo_d = {quo_q[DATA_W-2:0], 1'b1};
    end else begin
      rem_d = trial[DATA_W-1:0];
      quo_d = {quo_q[DATA_W-2:0], 1'b0};
    end
    fix_quo = (signed_q && (a_neg_q ^ b_neg_q)) ? -quo_d : quo_d;
    fix_rem = (signed_q && a_neg_q) ? -rem_d : rem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      res_q     <= '0;
      signed_q  <= 1'b0;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      result_o  <= '0;
      ready_o   <= DivResultNotReady;
    end else begin
      case (state_q)
        DivFree: begin
          result_o <= '0;
          ready_o  <= DivResultNotReady;
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == '0) begin
              state_q <= DivByZero;
            end else begin
              state_q   <= DivOn;
              cnt_q     <= '0;
              rem_q     <= '0;
              quo_q     <= a_abs;
              divisor_q <= b_abs;
              signed_q  <= signed_div_i;
              a_neg_q   <= a_neg;
              b_neg_q   <= b_neg;
            end
          end
        end

        DivByZero: begin
          res_q   <= '0;
          state_q <= annul_i ? DivFree : DivEnd;
        end

        DivOn: begin
          if (annul_i) begin
            state_q <= DivFree;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
              state_q <= DivEnd;
              res_q   <= {fix_rem, fix_quo};
            end
          end
        end

        DivEnd: begin
          if (annul_i || start_i == DivStop) begin
            state_q  <= DivFree;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end else begin
            result_o <= res_q;
            ready_o  <= DivResultReady;
          end
        end

        default: begin
          state_q  <= DivFree;
          result_o <= '0;
          ready_o  <= DivResultNotReady;
        end
      endcase
    end
  end

endmodule
